// File: rtl/mem_access_pkg.sv
// Shared state encoding and data helpers for mem_access_master and its bench.
// Width-generic helpers take the active width/depth as an argument.
package mem_access_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StIssue   = 2'd1;
    localparam state_t StCapture = 2'd2;
    localparam state_t StResp    = 2'd3;

    // Exchanges the upper and lower width/2 halves of the low 'width' bits of data.
    function automatic logic [63:0] half_swap(input logic [63:0] data, input int unsigned width);
        logic [63:0] mask;
        logic [63:0] low;
        int unsigned h;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        h    = width / 2;
        low  = data & mask;
        return ((low >> h) | (low << h)) & mask;
    endfunction

    function automatic logic is_upper(input logic [31:0] addr, input int unsigned depth);
        return addr >= 32'(depth / 2);
    endfunction

endpackage

// File: rtl/mem_access_master.sv
// Host-to-memory request master: one outstanding request, registered strobes, and
// half-swap removal on upper-half reads. Optional counters: MEM_ACCESS_MASTER_STATS_EN.
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PSIZE = 4,
    parameter int unsigned DEPTH = 2 ** PSIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [PSIZE-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             mem_wr,
    output logic             mem_rd,
    output logic [PSIZE-1:0] mem_waddr,
    output logic [PSIZE-1:0] mem_raddr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
`ifdef MEM_ACCESS_MASTER_STATS_EN
    ,
    output logic [15:0]      wr_count,
    output logic [15:0]      rd_count
`endif
);

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [PSIZE-1:0]   addr_q, addr_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               mem_wr_q, mem_wr_d;
    logic               mem_rd_q, mem_rd_d;
    logic [PSIZE-1:0]   mem_waddr_q, mem_waddr_d;
    logic [PSIZE-1:0]   mem_raddr_q, mem_raddr_d;
    logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [63:0]        swapped;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        mem_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_raddr_d = mem_raddr_q;
        mem_wdata_d = mem_wdata_q;
        swapped     = half_swap(64'(mem_rdata), WIDTH);

        case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    state_d = StIssue;
                    // Strobes are registered, so they are launched from the handshake itself.
                    if (req_we) begin
                        mem_wr_d    = 1'b1;
                        mem_waddr_d = req_addr;
                        mem_wdata_d = req_wdata;
                    end else begin
                        mem_rd_d    = 1'b1;
                        mem_raddr_d = req_addr;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            StIssue: begin
                if (we_q) begin
                    state_d     = StIdle;
                    req_ready_d = 1'b1;
                end else begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                rsp_data_d  = is_upper(32'(addr_q), DEPTH) ? swapped[WIDTH-1:0] : mem_rdata;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            addr_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_raddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_waddr_q <= mem_waddr_d;
            mem_raddr_q <= mem_raddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_raddr = mem_raddr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_ACCESS_MASTER_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (mem_wr_d && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if (rsp_valid_q && rsp_ready && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`endif

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator/reader side of the single-port write/read memory interface.
- Accepts host read/write requests over a valid/ready handshake and drives the memory strobes, addresses and data.
- Never asserts write and read strobes in the same cycle.
- Captures the registered memory read data and undoes the half-swap the memory applies to upper-half addresses, so host write-then-read round trips are identity.
- Sits between a host/bus adapter and the memory array.

Parameters:
- WIDTH, 8, data width; must be even.
- PSIZE, 4, address width.
- DEPTH, 2**PSIZE, number of words; upper half is addresses >= DEPTH/2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  master can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  PSIZE  request address.
- req_wdata  input  WIDTH  write data (logical, unswapped).
- rsp_valid  output  1  read response valid.
- rsp_ready  input  1  host accepts response.
- rsp_data  output  WIDTH  read data (logical).
- mem_wr  output  1  memory write strobe.
- mem_rd  output  1  memory read strobe.
- mem_waddr  output  PSIZE  memory write address.
- mem_raddr  output  PSIZE  memory read address.
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  memory registered read data; valid the cycle after mem_rd.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0 during reset, 1 in the first cycle after reset; rsp_valid=0, rsp_data=0, mem_wr=0, mem_rd=0, addresses=0, mem_wdata=0.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch we/addr/wdata, go to ISSUE.
  - The memory strobe rises in the following cycle.
- ISSUE (1 cycle):
  - Write: mem_wr=1, mem_waddr=addr, mem_wdata=wdata passed raw (the memory applies the swap itself); next state IDLE.
  - Read: mem_rd=1, mem_raddr=addr; next state CAPTURE.
  - mem_wr and mem_rd are mutually exclusive in every cycle.
- CAPTURE (1 cycle):
  - Sample mem_rdata.
  - If addr < DEPTH/2: rsp_data = mem_rdata.
  - Otherwise rsp_data = {mem_rdata[WIDTH/2-1:0], mem_rdata[WIDTH-1:WIDTH/2]}.
  - Set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid and rsp_data stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid=0, go to IDLE.
- req_ready=0 in ISSUE, CAPTURE and RESP; no pipelining.
  - Write occupancy: 2 cycles.
  - Read occupancy: 3 cycles plus response backpressure.
- Boundary conditions:
  - Address DEPTH/2-1 is lower half (no swap); DEPTH/2 is upper half (swap).
  - Address DEPTH-1 has no wrap or overflow handling; it is just a word.
  - A req_valid deassertion while req_ready=0 has no effect; a request is taken only on the handshake.
- Reset mid-operation:
  - Any state returns to IDLE next cycle.
  - Pending strobe is dropped; rsp_valid is cleared; the latched request is discarded.
  - The memory is reset concurrently, so a subsequent read returns 0.
- Strobes are single-cycle pulses; back-to-back requests have at least one idle strobe cycle between them.

Optional Feature:
- Macro: MEM_ACCESS_MASTER_STATS_EN.
- When defined:
  - Adds outputs wr_count and rd_count, each 16 bits.
  - wr_count increments on each mem_wr pulse; rd_count increments on each completed response handshake.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_access_pkg holds:
  - State enum (IDLE, ISSUE, CAPTURE, RESP).
  - Function half_swap(data) swapping the upper and lower WIDTH/2 halves.
  - Function is_upper(addr), returning addr >= DEPTH/2.
- No sub-module; the swap is a package function.
- Testbench reuses half_swap and is_upper for its reference model.

Test Plan:
- Reset, then write 0x3C to addr 2 and read addr 2 -> mem_wdata=0x3C, mem_rdata=0x3C, rsp_data=0x3C, rsp_valid 3 cycles after the read handshake.
- Write 0xA5 to addr 9, then read addr 9 -> mem_rdata=0x5A (raw), rsp_data=0xA5.
- Boundary: write 0x12 to addr 7 and 0x34 to addr 8, read both -> rsp_data 0x12 and 0x34; mem_rdata 0x12 and 0x43.
- Hold rsp_ready=0 for 5 cycles on a read -> rsp_valid and rsp_data stable, req_ready=0 throughout, no mem strobe; release -> IDLE next cycle.
- Drop rst_n during CAPTURE of a read to addr 9 -> next cycle rsp_valid=0, mem_rd=0, state IDLE; a later read of addr 9 returns 0x00.
- Random 1000 mixed requests against the package-function model -> mem_wr && mem_rd never both 1; all responses match the model; with STATS_EN, the counts equal the number of issued writes and completed reads.
